// File: rtl/counter_nbit_if.sv
// Control and status bundle for counter_nbit: the controller owns en/up/load/load_val,
// the counter returns the registered count and terminal-count flag.
interface counter_nbit_if #(
  parameter int WIDTH = 20
) ();
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;

  modport master (
    output en, up, load, load_val,
    input  count, tc
  );

  modport slave (
    input  en, up, load, load_val,
    output count, tc
  );
endinterface

// File: rtl/counter_nbit.sv
// Parametrised up/down counter with clamped load, wrap/saturate mode and a terminal-count pulse.
// Optional prescaler selected by defining COUNTER_PRESCALE_EN.
module counter_nbit #(
  parameter int               WIDTH     = 20,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
  parameter int               SATURATE  = 0,
  parameter int               PRESCALE  = 1
) (
  input  logic          clk,
  input  logic          rst,
  counter_nbit_if.slave bus
);

  if (WIDTH < 2) begin : g_bad_width
    $error("counter_nbit: WIDTH must be at least 2");
  end
  if (MAX_COUNT == '0) begin : g_bad_max
    $error("counter_nbit: MAX_COUNT must be at least 1");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("counter_nbit: PRESCALE must be at least 1");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             tick;
  logic             step;
  logic             at_max;
  logic             at_zero;

`ifdef COUNTER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase_q, phase_d;

  assign tick = (phase_q == PHASE_LAST);

  // Phase advances only on enabled cycles, so en=0 freezes a partial period.
  always_comb begin
    phase_d = phase_q;
    if (bus.load) begin
      phase_d = '0;
    end else if (bus.en) begin
      phase_d = tick ? '0 : phase_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  assign step    = bus.en && tick;
  assign at_max  = (count_q == MAX_COUNT);
  assign at_zero = (count_q == '0);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (bus.load) begin
      count_d = (bus.load_val > MAX_COUNT) ? MAX_COUNT : bus.load_val;
    end else if (step) begin
      if (bus.up) begin
        if (at_max) begin
          tc_d    = 1'b1;
          count_d = (SATURATE != 0) ? MAX_COUNT : '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          tc_d    = 1'b1;
          count_d = (SATURATE != 0) ? '0 : MAX_COUNT;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;

endmodule

// File: tb/tb_counter_nbit.sv
// Bench for counter_nbit: three WIDTH=3, MAX_COUNT=5 instances (wrap, saturate, prescale 3)
// driven by directed cycles; expected {count,tc} values are queued and checked by monitors.
module tb_counter_nbit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  counter_nbit_if #(.WIDTH(3)) a_if ();
  counter_nbit_if #(.WIDTH(3)) s_if ();
  counter_nbit_if #(.WIDTH(3)) p_if ();

  counter_nbit #(.WIDTH(3), .MAX_COUNT(3'd5), .SATURATE(0), .PRESCALE(1)) u_wrap (
    .clk(clk), .rst(rst), .bus(a_if)
  );
  counter_nbit #(.WIDTH(3), .MAX_COUNT(3'd5), .SATURATE(1), .PRESCALE(1)) u_sat (
    .clk(clk), .rst(rst), .bus(s_if)
  );
  counter_nbit #(.WIDTH(3), .MAX_COUNT(3'd5), .SATURATE(0), .PRESCALE(3)) u_pre (
    .clk(clk), .rst(rst), .bus(p_if)
  );

  // ---------------- scoreboard ----------------
  logic [3:0] exp_a_q[$];
  logic [3:0] exp_s_q[$];
  logic [3:0] exp_p_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: count=%0d tc=%0b, expected count=%0d tc=%0b at %0t",
               name, act[3:1], act[0], exp[3:1], exp[0], $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_a_q.size() > 0) check("wrap", {a_if.count, a_if.tc}, exp_a_q.pop_front());
    if (exp_s_q.size() > 0) check("sat",  {s_if.count, s_if.tc}, exp_s_q.pop_front());
    if (exp_p_q.size() > 0) check("pre",  {p_if.count, p_if.tc}, exp_p_q.pop_front());
  end

  // ---------------- driver tasks ----------------
  task automatic idle_all();
    a_if.en = 1'b0; a_if.up = 1'b1; a_if.load = 1'b0; a_if.load_val = 3'd0;
    s_if.en = 1'b0; s_if.up = 1'b1; s_if.load = 1'b0; s_if.load_val = 3'd0;
    p_if.en = 1'b0; p_if.up = 1'b1; p_if.load = 1'b0; p_if.load_val = 3'd0;
  endtask

  // One clock of stimulus on instance d (0 wrap, 1 sat, 2 prescale); others idle.
  task automatic cyc(input int d, input bit e, input bit u, input bit l,
                     input logic [2:0] lv, input logic [2:0] ec, input bit et);
    @(negedge clk);
    rst = 1'b1;
    idle_all();
    case (d)
      0: begin a_if.en = e; a_if.up = u; a_if.load = l; a_if.load_val = lv; exp_a_q.push_back({ec, et}); end
      1: begin s_if.en = e; s_if.up = u; s_if.load = l; s_if.load_val = lv; exp_s_q.push_back({ec, et}); end
      default: begin p_if.en = e; p_if.up = u; p_if.load = l; p_if.load_val = lv; exp_p_q.push_back({ec, et}); end
    endcase
  endtask

  // Reset cycle with en and load asserted everywhere; both must be ignored.
  task automatic cyc_rst();
    @(negedge clk);
    rst = 1'b0;
    a_if.en = 1'b1; a_if.up = 1'b1; a_if.load = 1'b1; a_if.load_val = 3'd3;
    s_if.en = 1'b1; s_if.up = 1'b1; s_if.load = 1'b1; s_if.load_val = 3'd3;
    p_if.en = 1'b1; p_if.up = 1'b1; p_if.load = 1'b1; p_if.load_val = 3'd3;
    exp_a_q.push_back(4'b0000);
    exp_s_q.push_back(4'b0000);
    exp_p_q.push_back(4'b0000);
  endtask

  // ---------------- stimulus ----------------
  int p_en  [11];
  int p_cnt [11];
  int p_tc  [11];
  int p_cnt2[3];
  int p_tc2 [3];

  initial begin
    rst = 1'b0;
    idle_all();
    p_en = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
`ifdef COUNTER_PRESCALE_EN
    p_cnt  = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3};
    p_tc   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    p_cnt2 = '{5, 5, 0};
    p_tc2  = '{0, 0, 1};
`else
    p_cnt  = '{1, 2, 3, 4, 5, 0, 1, 1, 1, 2, 3};
    p_tc   = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    p_cnt2 = '{0, 1, 2};
    p_tc2  = '{1, 0, 0};
`endif

    cyc_rst();
    cyc_rst();

    // Wrap up from 0: 1,2,3,4,5,0(tc),1,2
    cyc(0, 1, 1, 0, 3'd0, 3'd1, 0);
    cyc(0, 1, 1, 0, 3'd0, 3'd2, 0);
    cyc(0, 1, 1, 0, 3'd0, 3'd3, 0);
    cyc(0, 1, 1, 0, 3'd0, 3'd4, 0);
    cyc(0, 1, 1, 0, 3'd0, 3'd5, 0);
    cyc(0, 1, 1, 0, 3'd0, 3'd0, 1);
    cyc(0, 1, 1, 0, 3'd0, 3'd1, 0);
    cyc(0, 1, 1, 0, 3'd0, 3'd2, 0);

    // Mid-count reset, then resume counting
    cyc(0, 1, 1, 0, 3'd0, 3'd3, 0);
    cyc(0, 1, 1, 0, 3'd0, 3'd4, 0);
    cyc_rst();
    cyc_rst();
    cyc(0, 1, 1, 0, 3'd0, 3'd1, 0);

    // Clamped load, then load overriding a step
    cyc(0, 0, 1, 1, 3'd7, 3'd5, 0);
    cyc(0, 1, 1, 1, 3'd2, 3'd2, 0);

    // Direction flip: up to 3, then down 2,1,0, wrap to 5 with tc
    cyc(0, 1, 1, 0, 3'd0, 3'd3, 0);
    cyc(0, 1, 0, 0, 3'd0, 3'd2, 0);
    cyc(0, 1, 0, 0, 3'd0, 3'd1, 0);
    cyc(0, 1, 0, 0, 3'd0, 3'd0, 0);
    cyc(0, 1, 0, 0, 3'd0, 3'd5, 1);
    cyc(0, 0, 0, 0, 3'd0, 3'd5, 0);
    cyc(0, 1, 1, 0, 3'd0, 3'd0, 1);
    // Load at a boundary suppresses the step and its tc
    cyc(0, 1, 0, 1, 3'd4, 3'd4, 0);
    cyc(0, 0, 1, 1, 3'd5, 3'd5, 0);

    // Saturate: hold at 0 going down, hold at 5 going up
    cyc(1, 0, 0, 1, 3'd0, 3'd0, 0);
    cyc(1, 1, 0, 0, 3'd0, 3'd0, 1);
    cyc(1, 1, 0, 0, 3'd0, 3'd0, 1);
    cyc(1, 1, 0, 0, 3'd0, 3'd0, 1);
    cyc(1, 1, 1, 0, 3'd0, 3'd1, 0);
    cyc(1, 0, 1, 1, 3'd6, 3'd5, 0);
    cyc(1, 1, 1, 0, 3'd0, 3'd5, 1);
    cyc(1, 1, 1, 0, 3'd0, 3'd5, 1);
    cyc(1, 0, 1, 0, 3'd0, 3'd5, 0);
    cyc(1, 1, 0, 0, 3'd0, 3'd4, 0);

    // Prescale instance: en pattern with a two-cycle pause mid-period
    cyc(2, 0, 1, 1, 3'd0, 3'd0, 0);
    for (int i = 0; i < 11; i++) begin
      cyc(2, p_en[i] != 0, 1, 0, 3'd0, 3'(p_cnt[i]), p_tc[i] != 0);
    end
    cyc(2, 1, 1, 1, 3'd5, 3'd5, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(2, 1, 1, 0, 3'd0, 3'(p_cnt2[i]), p_tc2[i] != 0);
    end

    @(negedge clk);
    idle_all();
    for (int i = 0; i < 10; i++) begin
      if (exp_a_q.size() == 0 && exp_s_q.size() == 0 && exp_p_q.size() == 0) break;
      @(negedge clk);
    end
    tests_run++;
    if (exp_a_q.size() + exp_s_q.size() + exp_p_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0",
               exp_a_q.size() + exp_s_q.size() + exp_p_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
